mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory/peripheral port (SRAM over SPI, GPIO, UART, I2C, control regs)
//  between two requesters: port 0 = instruction fetch, port 1 = data load/store.
//  Sequences the port's ce-low / busy / valid / fault handshake, returns read data and
//  fault status to the winner, and bounds every access with a timeout.
// PARAMETERS
//  RR_EN          1        1 = round-robin between ports; 0 = fixed priority, port 1 wins
//  TIMEOUT_CYCLES 1048575  WAIT cycles before abort with fault; 0 = no timeout
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-low reset
//  req[1:0]     in   2   per-port request level; held high until that port's ack
//  addr0/addr1  in   32  per-port byte address
//  funct3_0/_1  in   3   per-port access size/sign code, passed through unchanged
//  wdata0/_1    in   32  per-port write data
//  we[1:0]      in   2   per-port write enable (1 = store)
//  ack[1:0]     out  2   one-cycle completion pulse to the granted port
//  rdata        out  32  read data; valid while ack is high
//  fault        out  1   qualifies ack: access faulted or timed out
//  mem_ce       out  1   port chip enable, active low
//  mem_funct3   out  3   latched funct3
//  mem_addr     out  32  latched address
//  mem_datain   out  32  latched write data
//  mem_memwrite out  1   latched write enable
//  mem_dataout  in   32  port read data
//  mem_busy     in   1   port busy
//  mem_valid    in   1   port read-data valid (held until ce high)
//  mem_fault    in   1   port load_access_fault (held until ce high)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, mem_ce=1, ack=0, fault=0, rdata=0,
//    mem_* latches=0, last_grant=1, timeout counter=0. Reset mid-access is an abort:
//    no ack is produced, and mem_ce=1 returns the port to its idle state.
//  - IDLE: mem_ce=1. If req!=0, pick the winner, latch its addr/funct3/wdata/we into mem_*,
//    record grant, go START. Arbitration: RR_EN=1 -> if both request, the port that did not
//    win last takes the grant; RR_EN=0 -> port 1 whenever req[1]. Only IDLE arbitrates.
//  - START: mem_ce=0 for one cycle (port samples its request); clear seen_busy and the
//    counter; go WAIT.
//  - WAIT: mem_ce=0. Each cycle: seen_busy |= mem_busy; counter++. Exit priority:
//      1 mem_fault                  -> fault=1, rdata=0
//      2 mem_valid                  -> fault=0, rdata=mem_dataout
//      3 seen_busy && !mem_busy     -> fault=0, rdata=mem_dataout
//        (completes writes and GPIO/control-register reads, which finish without valid)
//      4 TIMEOUT_CYCLES!=0 && counter==TIMEOUT_CYCLES-1 -> fault=1, rdata=0
//    Any exit -> RESP. Priority 3 is ignored until busy has been seen high at least once.
//  - RESP: mem_ce=1, ack[grant]=1 for exactly this cycle; rdata/fault held until the next
//    ack. Go IDLE. mem_ce is high for at least 2 cycles (RESP+IDLE) between accesses.
//  - Latency: uncontended access = 1 (IDLE) + 1 (START) + port WAIT cycles + 1 (RESP).
//  - After grant, a requester dropping req does not cancel the access; ack still pulses.
//  - ack is never asserted on both bits; ack is never asserted outside RESP.
//  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.
//  - mem_* outputs stay stable from START through RESP; they change only in IDLE.
// TESTING
//  1 req=01, addr0=0x100, SRAM model returns 0xDEADBEEF -> ack=01, rdata=0xDEADBEEF, fault=0.
//  2 req=11 both held, RR_EN=1 -> grants alternate 1,0,1,0;
//    RR_EN=0 -> port 1 is served back-to-back until req[1]=0.
//  3 port 1 write to 0x00800000 (GPIO out; busy 1 cycle, no valid) -> ack=10, fault=0,
//    mem_ce high >=2 cycles afterwards.
//  4 port 0 read of 0x01000000 (port raises mem_fault) -> ack=01, fault=1, rdata=0.
//  5 TIMEOUT_CYCLES=16, port holds mem_busy=1 forever -> ack + fault exactly 16 WAIT
//    cycles after START.
//  6 reset low mid-WAIT -> next cycle mem_ce=1, ack=0; a held req re-arbitrates after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared memory/peripheral port: picks a winner, runs the
// ce-low / busy / valid / fault handshake with a timeout, and returns data and fault status.
module mem_port_arbiter #(
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [2:0]  funct3_0,
  input  logic [2:0]  funct3_1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [1:0]  we,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_memwrite,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_fault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             seen_busy, seen_busy_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       ack_nxt;
  logic [31:0]      rdata_nxt;
  logic             fault_nxt;
  logic             mem_ce_nxt;
  logic [2:0]       mem_funct3_nxt;
  logic [31:0]      mem_addr_nxt;
  logic [31:0]      mem_datain_nxt;
  logic             mem_memwrite_nxt;
  logic             win;
  logic             done;

  // Winner for this IDLE cycle; grant doubles as the last-winner record for round-robin.
  always_comb begin
    win = req[1];
    if (req[0] && req[1]) begin
      win = RR_EN ? ~grant : 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    grant_nxt        = grant;
    seen_busy_nxt    = seen_busy;
    cnt_nxt          = cnt;
    ack_nxt          = 2'b00;
    rdata_nxt        = rdata;
    fault_nxt        = fault;
    mem_ce_nxt       = 1'b1;
    mem_funct3_nxt   = mem_funct3;
    mem_addr_nxt     = mem_addr;
    mem_datain_nxt   = mem_datain;
    mem_memwrite_nxt = mem_memwrite;
    done             = 1'b0;

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_nxt        = win;
          mem_addr_nxt     = win ? addr1    : addr0;
          mem_funct3_nxt   = win ? funct3_1 : funct3_0;
          mem_datain_nxt   = win ? wdata1   : wdata0;
          mem_memwrite_nxt = win ? we[1]    : we[0];
          mem_ce_nxt       = 1'b0;
          state_nxt        = S_START;
        end
      end

      S_START: begin
        seen_busy_nxt = 1'b0;
        cnt_nxt       = '0;
        mem_ce_nxt    = 1'b0;
        state_nxt     = S_WAIT;
      end

      S_WAIT: begin
        mem_ce_nxt    = 1'b0;
        seen_busy_nxt = seen_busy | mem_busy;
        cnt_nxt       = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        // Busy falling after having been seen completes accesses that never raise valid.
        if (mem_fault) begin
          done      = 1'b1;
          fault_nxt = 1'b1;
          rdata_nxt = 32'h0;
        end else if (mem_valid || (seen_busy && !mem_busy)) begin
          done      = 1'b1;
          fault_nxt = 1'b0;
          rdata_nxt = mem_dataout;
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          done      = 1'b1;
          fault_nxt = 1'b1;
          rdata_nxt = 32'h0;
        end
        if (done) begin
          mem_ce_nxt = 1'b1;
          ack_nxt    = {grant, ~grant};
          state_nxt  = S_RESP;
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; a reset mid-access drops it without an ack.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      grant        <= 1'b1;
      seen_busy    <= 1'b0;
      cnt          <= '0;
      ack          <= 2'b00;
      rdata        <= 32'h0;
      fault        <= 1'b0;
      mem_ce       <= 1'b1;
      mem_funct3   <= 3'h0;
      mem_addr     <= 32'h0;
      mem_datain   <= 32'h0;
      mem_memwrite <= 1'b0;
    end else begin
      state        <= state_nxt;
      grant        <= grant_nxt;
      seen_busy    <= seen_busy_nxt;
      cnt          <= cnt_nxt;
      ack          <= ack_nxt;
      rdata        <= rdata_nxt;
      fault        <= fault_nxt;
      mem_ce       <= mem_ce_nxt;
      mem_funct3   <= mem_funct3_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_datain   <= mem_datain_nxt;
      mem_memwrite <= mem_memwrite_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin arbiter and a fixed-priority arbiter, each on its own
// behavioural port model (SRAM, GPIO write, faulting read, hung peripheral).
module tb_mem_port_arbiter;

  localparam int M_SRAM  = 0;
  localparam int M_GPIO  = 1;
  localparam int M_FAULT = 2;
  localparam int M_HANG  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_a = 2'b00;
  logic [1:0]  req_b = 2'b00;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic [2:0]  f3_0 = 3'h0, f3_1 = 3'h0;
  logic [1:0]  we = 2'b00;

  logic [1:0]  ack_m   [2];
  logic [31:0] rdata_m [2];
  logic        fault_m [2];
  logic        ce_m    [2];
  logic [2:0]  mf3_m   [2];
  logic [31:0] maddr_m [2];
  logic [31:0] mdin_m  [2];
  logic        mwr_m   [2];
  logic [31:0] dout_m  [2] = '{32'h0, 32'h0};
  logic        busy_m  [2] = '{1'b0, 1'b0};
  logic        valid_m [2] = '{1'b0, 1'b0};
  logic        flt_m   [2] = '{1'b0, 1'b0};
  int          cnt_m   [2] = '{0, 0};

  int mode = M_SRAM;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset), .req(req_a),
    .addr0(addr0), .addr1(addr1), .funct3_0(f3_0), .funct3_1(f3_1),
    .wdata0(wdata0), .wdata1(wdata1), .we(we),
    .ack(ack_m[0]), .rdata(rdata_m[0]), .fault(fault_m[0]),
    .mem_ce(ce_m[0]), .mem_funct3(mf3_m[0]), .mem_addr(maddr_m[0]),
    .mem_datain(mdin_m[0]), .mem_memwrite(mwr_m[0]),
    .mem_dataout(dout_m[0]), .mem_busy(busy_m[0]), .mem_valid(valid_m[0]),
    .mem_fault(flt_m[0])
  );

  mem_port_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset), .req(req_b),
    .addr0(addr0), .addr1(addr1), .funct3_0(f3_0), .funct3_1(f3_1),
    .wdata0(wdata0), .wdata1(wdata1), .we(we),
    .ack(ack_m[1]), .rdata(rdata_m[1]), .fault(fault_m[1]),
    .mem_ce(ce_m[1]), .mem_funct3(mf3_m[1]), .mem_addr(maddr_m[1]),
    .mem_datain(mdin_m[1]), .mem_memwrite(mwr_m[1]),
    .mem_dataout(dout_m[1]), .mem_busy(busy_m[1]), .mem_valid(valid_m[1]),
    .mem_fault(flt_m[1])
  );

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5A5A5);
  endfunction

  // Port models: cnt counts cycles since ce fell; valid/fault hold until ce rises.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ce_m[g]) begin
        cnt_m[g]   <= 0;
        busy_m[g]  <= 1'b0;
        valid_m[g] <= 1'b0;
        flt_m[g]   <= 1'b0;
        dout_m[g]  <= 32'h0;
      end else begin
        cnt_m[g] <= cnt_m[g] + 1;
        case (mode)
          M_SRAM: begin
            busy_m[g]  <= (cnt_m[g] < 2);
            valid_m[g] <= (cnt_m[g] >= 2);
            dout_m[g]  <= (cnt_m[g] >= 2) ? sram_word(maddr_m[g]) : 32'h0;
          end
          M_GPIO: begin
            busy_m[g] <= (cnt_m[g] == 0);
            dout_m[g] <= 32'h000000F0;
          end
          M_FAULT: begin
            busy_m[g] <= (cnt_m[g] == 0);
            flt_m[g]  <= (cnt_m[g] >= 1);
            dout_m[g] <= 32'hFFFFFFFF;
          end
          default: begin
            busy_m[g] <= 1'b1;
            dout_m[g] <= 32'hFFFFFFFF;
          end
        endcase
      end
    end
  end

  // Waits (bounded) for an ack on arbiter d; a timeout returns a = 0.
  task automatic wait_ack(input int d, input int bound, output logic [1:0] a,
                          output int n, output int low);
    a = 2'b00;
    n = 0;
    low = 0;
    while (n < bound && a == 2'b00) begin
      @(negedge clk);
      n++;
      if (ce_m[d] == 1'b0) low++;
      a = ack_m[d];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ce_m[0], ack_m[0], fault_m[0]} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctl_a: ce/ack/fault=%b required 1000", {ce_m[0], ack_m[0], fault_m[0]});
    end
    total++;
    if ({ce_m[1], ack_m[1], fault_m[1]} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctl_b: ce/ack/fault=%b required 1000", {ce_m[1], ack_m[1], fault_m[1]});
    end
    total++;
    if ({rdata_m[0], maddr_m[0], mdin_m[0], mf3_m[0], mwr_m[0]} !== 100'h0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h addr=%h din=%h f3=%h wr=%b required all 0",
               rdata_m[0], maddr_m[0], mdin_m[0], mf3_m[0], mwr_m[0]);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [1:0] a;
    int n, low;
    mode = M_SRAM; addr0 = 32'h100; f3_0 = 3'b010; we = 2'b00;
    req_a = 2'b01;
    wait_ack(0, 40, a, n, low);
    req_a = 2'b00;
    total++;
    if (a !== 2'b01 || rdata_m[0] !== 32'hDEADBEEF || fault_m[0] !== 1'b0) begin
      bad++;
      $display("FAIL read_sram: ack=%b rdata=%h fault=%b required 01 deadbeef 0",
               a, rdata_m[0], fault_m[0]);
    end
    total++;
    if (n != 5 || low != 4) begin
      bad++;
      $display("FAIL read_latency: cycles=%0d ce_low=%0d required 5 4", n, low);
    end
    total++;
    if (maddr_m[0] !== 32'h100 || mf3_m[0] !== 3'b010 || mwr_m[0] !== 1'b0) begin
      bad++;
      $display("FAIL read_latch: addr=%h f3=%b wr=%b required 100 010 0",
               maddr_m[0], mf3_m[0], mwr_m[0]);
    end
    @(negedge clk);
    total++;
    if (ack_m[0] !== 2'b00 || rdata_m[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_pulse: ack=%b rdata=%h required 00 deadbeef", ack_m[0], rdata_m[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] a;
    int n, low;
    logic exp_g;
    mode = M_SRAM; addr0 = 32'h200; addr1 = 32'h300;
    req_a = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0);
      wait_ack(0, 40, a, n, low);
      if (i == 3) req_a = 2'b00;
      total++;
      if (a !== {exp_g, ~exp_g} ||
          rdata_m[0] !== sram_word(exp_g ? 32'h300 : 32'h200)) begin
        bad++;
        $display("FAIL rr_grant%0d: ack=%b rdata=%h required %b %h", i, a, rdata_m[0],
                 {exp_g, ~exp_g}, sram_word(exp_g ? 32'h300 : 32'h200));
      end
      total++;
      if (n != ((i == 0) ? 5 : 6)) begin
        bad++;
        $display("FAIL rr_spacing%0d: cycles=%0d required %0d", i, n, (i == 0) ? 5 : 6);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_gpio_write();
    logic [1:0] a;
    int n, low;
    mode = M_GPIO; addr1 = 32'h00800000; wdata1 = 32'h0000005A; f3_1 = 3'b010; we = 2'b10;
    req_a = 2'b10;
    wait_ack(0, 40, a, n, low);
    req_a = 2'b00; we = 2'b00;
    total++;
    if (a !== 2'b10 || fault_m[0] !== 1'b0 || low != 3) begin
      bad++;
      $display("FAIL gpio_ack: ack=%b fault=%b ce_low=%0d required 10 0 3", a, fault_m[0], low);
    end
    total++;
    if (maddr_m[0] !== 32'h00800000 || mdin_m[0] !== 32'h5A || mwr_m[0] !== 1'b1) begin
      bad++;
      $display("FAIL gpio_latch: addr=%h din=%h wr=%b required 00800000 5a 1",
               maddr_m[0], mdin_m[0], mwr_m[0]);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (ce_m[0] !== 1'b1) begin
        bad++;
        $display("FAIL gpio_ce_gap%0d: ce=%b required 1", i, ce_m[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fault();
    logic [1:0] a;
    int n, low;
    mode = M_FAULT; addr0 = 32'h01000000;
    req_a = 2'b01;
    wait_ack(0, 40, a, n, low);
    req_a = 2'b00;
    total++;
    if (a !== 2'b01 || fault_m[0] !== 1'b1 || rdata_m[0] !== 32'h0) begin
      bad++;
      $display("FAIL fault_read: ack=%b fault=%b rdata=%h required 01 1 0",
               a, fault_m[0], rdata_m[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [1:0] a;
    int n, low;
    mode = M_HANG; addr1 = 32'h02000000;
    req_a = 2'b10;
    wait_ack(0, 60, a, n, low);
    req_a = 2'b00;
    total++;
    if (a !== 2'b10 || fault_m[0] !== 1'b1 || rdata_m[0] !== 32'h0) begin
      bad++;
      $display("FAIL timeout_ack: ack=%b fault=%b rdata=%h required 10 1 0",
               a, fault_m[0], rdata_m[0]);
    end
    total++;
    if (low != 17 || n != 18) begin
      bad++;
      $display("FAIL timeout_len: ce_low=%0d cycles=%0d required 17 18", low, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] a;
    int n, low;
    mode = M_HANG; addr0 = 32'h00000400;
    req_a = 2'b01;
    repeat (5) @(negedge clk);
    total++;
    if (ce_m[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre: ce=%b required 0", ce_m[0]);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (ce_m[0] !== 1'b1 || ack_m[0] !== 2'b00) begin
        bad++;
        $display("FAIL abort_reset%0d: ce=%b ack=%b required 1 00", i, ce_m[0], ack_m[0]);
      end
    end
    reset = 1'b1; mode = M_SRAM;
    wait_ack(0, 40, a, n, low);
    req_a = 2'b00;
    total++;
    if (a !== 2'b01 || rdata_m[0] !== sram_word(32'h400) || n != 5) begin
      bad++;
      $display("FAIL abort_rearb: ack=%b rdata=%h cycles=%0d required 01 %h 5",
               a, rdata_m[0], n, sram_word(32'h400));
    end
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    logic [1:0] a;
    int n, low;
    logic exp_g;
    mode = M_SRAM; addr0 = 32'h200; addr1 = 32'h300;
    req_b = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i < 3);
      wait_ack(1, 40, a, n, low);
      if (i == 2) req_b = 2'b01;
      if (i == 3) req_b = 2'b00;
      total++;
      if (a !== {exp_g, ~exp_g} ||
          rdata_m[1] !== sram_word(exp_g ? 32'h300 : 32'h200)) begin
        bad++;
        $display("FAIL fp_grant%0d: ack=%b rdata=%h required %b %h", i, a, rdata_m[1],
                 {exp_g, ~exp_g}, sram_word(exp_g ? 32'h300 : 32'h200));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_round_robin();
    test_gpio_write();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_fixed_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
